yutorina_mem_slave: RTL and testbench

Word-wide data memory responder for the Yutorina CPU data bus, the far end of the MEM-stage memory controller. It samples the controller's active-low address strobe and read/write select, holds the request for a programmable number of wait cycles, then answers with a one-cycle active-low ready pulse. A read returns data during that pulse; a write commits to the internal RAM. Illegal accesses are flagged on an error line.

---
 rtl/yutorina_mem_slave_if.sv | 14 +
 rtl/yutorina_mem_slave.sv | 101 ++++++++++
 tb/tb_yutorina_mem_slave.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/yutorina_mem_slave_if.sv
// Data-bus bundle between the MEM-stage memory controller (master)
// and the data memory responder (slave).
interface yutorina_mem_slave_if;
  logic        as_;
  logic        rw;
  logic [31:0] addr;
  logic [31:0] w_data;
  logic [31:0] r_data;
  logic        rdy_;
  logic        err;

  modport master (output as_, rw, addr, w_data, input r_data, rdy_, err);
  modport slave  (input as_, rw, addr, w_data, output r_data, rdy_, err);
endinterface

// File: rtl/yutorina_mem_slave.sv
// Word-wide data memory responder: strobe sampled in IDLE, WAIT wait cycles,
// then a one-cycle active-low ready pulse carrying read data or an error flag.
module yutorina_mem_slave #(
  parameter int ADDR_W = 10,
  parameter int WAIT   = 1
) (
  input logic                  clk,
  input logic                  reset,
  yutorina_mem_slave_if.slave  bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

  state_t              state, state_d;
  logic [2:0]          cnt, cnt_d;
  logic [31:0]         addr_q, w_data_q;
  logic                rw_q;
  logic [31:0]         mem [2**ADDR_W];

  logic [31:0]         acc_addr;
  logic                acc_rw;
  logic                acc_legal;
  logic [ADDR_W-1:0]   acc_idx;

  logic                rdy_d, err_d;
  logic [31:0]         r_data_d;
  logic                rdy_q, err_q;
  logic [31:0]         r_data_q;

  // With WAIT=0 the ACK response is built in the same cycle the request is
  // sampled, so the live bus is used in IDLE and the latched copy otherwise.
  always_comb begin
    acc_addr  = (state == ST_IDLE) ? bus.addr : addr_q;
    acc_rw    = (state == ST_IDLE) ? bus.rw   : rw_q;
    acc_idx   = acc_addr[ADDR_W+1:2];
    acc_legal = (acc_addr[1:0] == 2'b00) && (acc_addr[31:ADDR_W+2] == '0);
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    rdy_d    = 1'b1;
    err_d    = 1'b0;
    r_data_d = 32'h0;
    case (state)
      ST_IDLE: begin
        if (!bus.as_) begin
          cnt_d   = 3'(WAIT);
          state_d = (WAIT > 0) ? ST_WAIT : ST_ACK;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt - 3'd1;
        if (cnt <= 3'd1) state_d = ST_ACK;
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Outputs are registered, so they are decided from the state being entered.
    if (state_d == ST_ACK) begin
      rdy_d = 1'b0;
      if (!acc_legal)  err_d    = 1'b1;
      else if (acc_rw) r_data_d = mem[acc_idx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= 3'd0;
      addr_q   <= 32'h0;
      w_data_q <= 32'h0;
      rw_q     <= 1'b1;
      rdy_q    <= 1'b1;
      err_q    <= 1'b0;
      r_data_q <= 32'h0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      rdy_q    <= rdy_d;
      err_q    <= err_d;
      r_data_q <= r_data_d;
      if (state == ST_IDLE && !bus.as_) begin
        addr_q   <= bus.addr;
        w_data_q <= bus.w_data;
        rw_q     <= bus.rw;
      end
    end
  end

  // Commit on the edge leaving ACK; a reset at that edge abandons the write.
  always_ff @(posedge clk) begin
    if (!reset && state == ST_ACK && !rw_q && acc_legal)
      mem[acc_idx] <= w_data_q;
  end

  assign bus.rdy_   = rdy_q;
  assign bus.err    = err_q;
  assign bus.r_data = r_data_q;

endmodule

// File: tb/tb_yutorina_mem_slave.sv
// Bench for yutorina_mem_slave: three instances (WAIT=0,1,3) driven by directed
// and random accesses, checked against a word-array model of the memory.
module tb_yutorina_mem_slave;

  logic clk;
  logic reset;

  yutorina_mem_slave_if bus0 ();
  yutorina_mem_slave_if bus1 ();
  yutorina_mem_slave_if bus2 ();

  logic        as_v  [3];
  logic        rw_v  [3];
  logic [31:0] addr_v[3];
  logic [31:0] wd_v  [3];

  assign bus0.as_ = as_v[0];  assign bus0.rw = rw_v[0];
  assign bus0.addr = addr_v[0]; assign bus0.w_data = wd_v[0];
  assign bus1.as_ = as_v[1];  assign bus1.rw = rw_v[1];
  assign bus1.addr = addr_v[1]; assign bus1.w_data = wd_v[1];
  assign bus2.as_ = as_v[2];  assign bus2.rw = rw_v[2];
  assign bus2.addr = addr_v[2]; assign bus2.w_data = wd_v[2];

  yutorina_mem_slave #(.ADDR_W(10), .WAIT(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  yutorina_mem_slave #(.ADDR_W(10), .WAIT(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  yutorina_mem_slave #(.ADDR_W(10), .WAIT(3)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  int          waits[3] = '{0, 1, 3};
  logic [31:0] mdl  [3][1024];
  bit          valid[3][1024];
  int          checks = 0;
  int          errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic get_out(input int d, output logic rdy, output logic err,
                         output logic [31:0] rd);
    case (d)
      0:       begin rdy = bus0.rdy_; err = bus0.err; rd = bus0.r_data; end
      1:       begin rdy = bus1.rdy_; err = bus1.err; rd = bus1.r_data; end
      default: begin rdy = bus2.rdy_; err = bus2.err; rd = bus2.r_data; end
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag, input int d);
    logic r, e;
    logic [31:0] rd;
    get_out(d, r, e, rd);
    check({tag, "_rdy"}, {31'b0, r}, 32'd1);
    check({tag, "_err"}, {31'b0, e}, 32'd0);
    check({tag, "_rdata"}, rd, 32'h0);
  endtask

  // One complete access on instance d; expected response comes from the model.
  task automatic do_access(input int d, input logic rw, input logic [31:0] a,
                           input logic [31:0] wd);
    logic r, e, legal, chk_data;
    logic [31:0] rd, exp_rd;
    legal    = (a[1:0] == 2'b00) && (a[31:12] == 20'h0);
    exp_rd   = 32'h0;
    chk_data = 1'b1;
    if (legal && rw) begin
      if (valid[d][a[11:2]]) exp_rd = mdl[d][a[11:2]];
      else chk_data = 1'b0;
    end
    @(negedge clk);
    as_v[d] = 1'b0; rw_v[d] = rw; addr_v[d] = a; wd_v[d] = wd;
    for (int k = 0; k <= waits[d]; k++) begin
      @(posedge clk); #1;
      get_out(d, r, e, rd);
      if (k < waits[d]) begin
        check("wait_rdy", {31'b0, r}, 32'd1);
      end else begin
        check("ack_rdy", {31'b0, r}, 32'd0);
        check("ack_err", {31'b0, e}, {31'b0, !legal});
        if (chk_data) check("ack_rdata", rd, exp_rd);
      end
    end
    as_v[d] = 1'b1;
    if (legal && !rw) begin
      mdl[d][a[11:2]]   = wd;
      valid[d][a[11:2]] = 1'b1;
    end
    @(posedge clk); #1;
    get_out(d, r, e, rd);
    check("post_rdy", {31'b0, r}, 32'd1);
  endtask

  initial begin
    logic r, e;
    logic [31:0] rd, a;
    for (int d = 0; d < 3; d++) begin
      as_v[d] = 1'b1; rw_v[d] = 1'b1; addr_v[d] = 32'h0; wd_v[d] = 32'h0;
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) check_idle("reset", d);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) check_idle("idle", d);
    end

    $display("[TB] write/read with WAIT=1");
    do_access(1, 1'b0, 32'h0000_0010, 32'hDEADBEEF);
    do_access(1, 1'b1, 32'h0000_0010, 32'h0);

    $display("[TB] misaligned write and out-of-range read");
    do_access(1, 1'b0, 32'h0000_0004, 32'h0BAD_0004);
    do_access(1, 1'b0, 32'h0000_0006, 32'hFFFF_FFFF);
    do_access(1, 1'b1, 32'h0000_0004, 32'h0);
    do_access(1, 1'b1, 32'h0000_1000, 32'h0);

    $display("[TB] back-to-back zero-wait reads");
    do_access(0, 1'b0, 32'h0, 32'd1);
    do_access(0, 1'b0, 32'h4, 32'd2);
    @(negedge clk);
    as_v[0] = 1'b0; rw_v[0] = 1'b1; addr_v[0] = 32'h0;
    @(posedge clk); #1;
    get_out(0, r, e, rd);
    check("b2b_rdy0", {31'b0, r}, 32'd0);
    check("b2b_data0", rd, 32'd1);
    addr_v[0] = 32'h4;
    @(posedge clk); #1;
    get_out(0, r, e, rd);
    check("b2b_gap", {31'b0, r}, 32'd1);
    @(posedge clk); #1;
    get_out(0, r, e, rd);
    check("b2b_rdy1", {31'b0, r}, 32'd0);
    check("b2b_data1", rd, 32'd2);
    as_v[0] = 1'b1;
    @(posedge clk); #1;
    check_idle("b2b_end", 0);

    $display("[TB] reset during WAIT");
    do_access(2, 1'b0, 32'h20, 32'hA5A5_0020);
    @(negedge clk);
    as_v[2] = 1'b0; rw_v[2] = 1'b0; addr_v[2] = 32'h20; wd_v[2] = 32'h12345678;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check_idle("midrst", 2);
    @(negedge clk);
    reset = 1'b0;
    as_v[2] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      get_out(2, r, e, rd);
      check("midrst_nordy", {31'b0, r}, 32'd1);
    end
    do_access(2, 1'b1, 32'h20, 32'h0);

    $display("[TB] random accesses");
    for (int i = 0; i < 60; i++) begin
      int d;
      int kind;
      d    = int'($urandom_range(0, 2));
      kind = int'($urandom_range(0, 9));
      a    = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      if (kind == 0) a[1:0] = 2'($urandom_range(1, 3));
      else if (kind == 1) a[31:12] = 20'($urandom_range(1, 20'hFFFFF));
      do_access(d, 1'($urandom_range(0, 1)), a, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
